// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined ripple-carry adder family.
// Provides the add/subtract mode encoding and the slice-width helper
// used by the top level's elaboration-time parameter check.
package adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Width of one ripple slice; returns 0 for a degenerate slice count so
    // the caller's consistency check rejects it instead of dividing by zero.
    function automatic int unsigned slice_w(input int unsigned width,
                                            input int unsigned slices);
        if (slices == 0) begin
            return 0;
        end
        return width / slices;
    endfunction

endpackage

// File: rtl/rc_slice_adder.sv
// Combinational SLICE_W-bit ripple-carry adder used as one pipeline slice.
// Ports:
//   a, b      : slice operands (b already inverted for subtraction)
//   cin       : carry into bit 0
//   sum       : slice result
//   cout      : carry out of the top bit
//   c_msb_in  : carry into the top bit (for signed overflow detection)
module rc_slice_adder #(
    parameter int unsigned SLICE_W = 4
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               c_msb_in
);

    logic c;

    always_comb begin
        sum      = '0;
        c        = cin;
        c_msb_in = cin;
        for (int unsigned i = 0; i < SLICE_W; i++) begin
            if (i == SLICE_W - 1) begin
                c_msb_in = c;
            end
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/pipelined_rc_adder.sv
// Pipelined WIDTH-bit add/subtract unit built from SLICES ripple slices,
// one slice per stage, with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready = pipe may advance)
//   in_a, in_b           : operands
//   in_cin               : carry-in for add; ignored when in_sub = 1
//   in_sub               : 0 = A+B+cin, 1 = A-B
//   out_valid / out_ready: result handshake
//   out_sum, out_cout    : result and carry out (subtract: 1 = no borrow)
//   out_ovf              : signed overflow
module pipelined_rc_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int SLICES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int SW = int'(slice_w(WIDTH, SLICES));

    if (WIDTH < 2 || SLICES < 1 || SW * SLICES != WIDTH) begin : g_bad_cfg
        $error("pipelined_rc_adder: WIDTH must be >= 2 and divisible by SLICES");
    end

    logic             adv;
    logic             push;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // The whole pipe moves together; a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign push     = in_valid && adv;
    assign b_eff    = (in_sub == MODE_SUB) ? ~in_b : in_b;
    assign c0       = (in_sub == MODE_ADD) ? in_cin : 1'b1;

    // Stage k adds slice k only. Lower result slices ride forward in s_q
    // (deskew); upper operand slices ride forward in a_up_q/b_up_q (skew).
    for (genvar k = 0; k < SLICES; k++) begin : g_st
        localparam int LO = k * SW;
        localparam int HI = LO + SW;

        logic [SW-1:0] a_sl;
        logic [SW-1:0] b_sl;
        logic [SW-1:0] s_sl;
        logic          c_in;
        logic          c_out;
        logic          v_in;
        logic [HI-1:0] s_acc;

        if (k == 0) begin : g_src
            assign a_sl  = in_a[SW-1:0];
            assign b_sl  = b_eff[SW-1:0];
            assign c_in  = c0;
            assign v_in  = push;
            assign s_acc = s_sl;
        end else begin : g_src
            assign a_sl  = g_st[k-1].g_mid.a_up_q[SW-1:0];
            assign b_sl  = g_st[k-1].g_mid.b_up_q[SW-1:0];
            assign c_in  = g_st[k-1].g_mid.c_q;
            assign v_in  = g_st[k-1].g_mid.v_q;
            assign s_acc = {s_sl, g_st[k-1].g_mid.s_q};
        end

        if (k < SLICES - 1) begin : g_mid
            logic [WIDTH-HI-1:0] a_up_d;
            logic [WIDTH-HI-1:0] b_up_d;
            logic [WIDTH-HI-1:0] a_up_q;
            logic [WIDTH-HI-1:0] b_up_q;
            logic [HI-1:0]       s_q;
            logic                c_q;
            logic                v_q;
            logic                c_msb_unused;

            rc_slice_adder #(.SLICE_W(SW)) u_slice (
                .a        (a_sl),
                .b        (b_sl),
                .cin      (c_in),
                .sum      (s_sl),
                .cout     (c_out),
                .c_msb_in (c_msb_unused)
            );

            if (k == 0) begin : g_up
                assign a_up_d = in_a[WIDTH-1:HI];
                assign b_up_d = b_eff[WIDTH-1:HI];
            end else begin : g_up
                assign a_up_d = g_st[k-1].g_mid.a_up_q[WIDTH-LO-1:SW];
                assign b_up_d = g_st[k-1].g_mid.b_up_q[WIDTH-LO-1:SW];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q    <= 1'b0;
                    c_q    <= 1'b0;
                    s_q    <= '0;
                    a_up_q <= '0;
                    b_up_q <= '0;
                end else if (adv) begin
                    v_q    <= v_in;
                    c_q    <= c_out;
                    s_q    <= s_acc;
                    a_up_q <= a_up_d;
                    b_up_q <= b_up_d;
                end
            end
        end else begin : g_last
            logic c_msb;

            rc_slice_adder #(.SLICE_W(SW)) u_slice (
                .a        (a_sl),
                .b        (b_sl),
                .cin      (c_in),
                .sum      (s_sl),
                .cout     (c_out),
                .c_msb_in (c_msb)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    out_sum   <= '0;
                    out_cout  <= 1'b0;
                    out_ovf   <= 1'b0;
                end else if (adv) begin
                    out_valid <= v_in;
                    out_sum   <= s_acc;
                    out_cout  <= c_out;
                    out_ovf   <= c_out ^ c_msb;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_rc_adder.sv
// Directed and scoreboard bench for pipelined_rc_adder in two
// configurations: WIDTH=16/SLICES=4 and WIDTH=8/SLICES=1.
module tb_pipelined_rc_adder;

    localparam int NR = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    // 16-bit, 4-slice instance
    logic        v16 = 0, ir16, cin16 = 0, sub16 = 0, ov16, rdy16 = 1, co16, of16;
    logic [15:0] a16 = 0, b16 = 0, sum16;
    // 8-bit, 1-slice instance
    logic        v8 = 0, ir8, cin8 = 0, sub8 = 0, ov8, rdy8 = 1, co8, of8;
    logic [7:0]  a8 = 0, b8 = 0, sum8;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    pipelined_rc_adder #(.WIDTH(16), .SLICES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v16), .in_ready(ir16), .in_a(a16), .in_b(b16),
        .in_cin(cin16), .in_sub(sub16),
        .out_valid(ov16), .out_ready(rdy16), .out_sum(sum16),
        .out_cout(co16), .out_ovf(of16)
    );

    pipelined_rc_adder #(.WIDTH(8), .SLICES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v8), .in_ready(ir8), .in_a(a8), .in_b(b8),
        .in_cin(cin8), .in_sub(sub8),
        .out_valid(ov8), .out_ready(rdy8), .out_sum(sum8),
        .out_cout(co8), .out_ovf(of8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: {ovf, cout, sum}; overflow from operand/result signs.
    function automatic logic [17:0] ref16(input logic [15:0] a, b, input logic cin, sub);
        logic [15:0] bb;
        logic [16:0] full;
        logic        ovf;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + 17'(sub ? 1'b1 : cin);
        ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
        return {ovf, full};
    endfunction

    function automatic logic [9:0] ref8(input logic [7:0] a, b, input logic cin, sub);
        logic [7:0] bb;
        logic [8:0] full;
        logic       ovf;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + 9'(sub ? 1'b1 : cin);
        ovf  = (a[7] == bb[7]) && (full[7] != a[7]);
        return {ovf, full};
    endfunction

    // One isolated operation; measures negedges between acceptance and result.
    task automatic dir_op(input bit big, input string tag,
                          input logic [15:0] a, b, input logic cin, sub,
                          input logic [15:0] es, input logic ec, eo);
        int lat;
        @(negedge clk);
        if (big) begin
            a16 = a; b16 = b; cin16 = cin; sub16 = sub; v16 = 1; rdy16 = 1;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; sub8 = sub; v8 = 1; rdy8 = 1;
        end
        #1 chk({tag, "_in_ready"}, big ? ir16 : ir8, 1);
        @(negedge clk);
        v16 = 0; v8 = 0; lat = 0;
        while (!(big ? ov16 : ov8) && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, big ? 3 : 0);
        chk({tag, "_sum"}, big ? sum16 : {8'h00, sum8}, es);
        chk({tag, "_cout"}, big ? co16 : co8, ec);
        chk({tag, "_ovf"}, big ? of16 : of8, eo);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [17:0] e16;
        logic [9:0]  e8;
        logic [17:0] q16[$];
        logic [9:0]  q8[$];
        int nin, nout, n8in, n8out;

        // Reset state
        #2 rst_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid16", ov16, 0);
        chk("rst_sum16", sum16, 0);
        chk("rst_cout16", co16, 0);
        chk("rst_ovf16", of16, 0);
        chk("rst_valid8", ov8, 0);
        chk("rst_sum8", sum8, 0);
        rst_n = 1;
        #1 chk("rst_in_ready16", ir16, 1);

        // Directed 16-bit vectors
        dir_op(1, "add_carry",  16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
        dir_op(1, "sub_borrow", 16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0);
        dir_op(1, "sub_ovf",    16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
        dir_op(1, "add_ovf",    16'h7FFF, 16'h0000, 1, 0, 16'h8000, 0, 1);
        dir_op(1, "sub_cin_ign",16'h0010, 16'h0010, 1, 1, 16'h0000, 1, 0);
        dir_op(1, "slice_cross",16'h0F0F, 16'h00F1, 0, 0, 16'h1000, 0, 0);
        dir_op(1, "cin_ripple", 16'h00FF, 16'h0000, 1, 0, 16'h0100, 0, 0);

        // Directed 8-bit, single-slice
        dir_op(0, "s1_add_ovf", 16'h0080, 16'h0080, 0, 0, 16'h0000, 1, 1);
        dir_op(0, "s1_sub",     16'h0003, 16'h0005, 0, 1, 16'h00FE, 0, 0);

        // Streaming with backpressure in cycles 6..8
        nin = 0; nout = 0; cin16 = 0; sub16 = 0;
        for (int c = 0; c < 40 && nout < 8; c++) begin
            @(negedge clk);
            rdy16 = !(c >= 6 && c <= 8);
            v16   = (nin < 8);
            a16   = 16'(nin);
            b16   = 16'(nin) << 12;
            #1;
            chk("strm_in_ready", ir16, !(c >= 6 && c <= 8));
            if (c >= 4 && nout < 8) chk("strm_valid", ov16, 1);
            if (ov16) begin
                chk("strm_sum", sum16, 16'(nout) + (16'(nout) << 12));
                chk("strm_cout", co16, 0);
                chk("strm_ovf", of16, 0);
                if (rdy16) nout++;
            end
            if (v16 && ir16) nin++;
        end
        chk("strm_count", nout, 8);
        @(negedge clk);
        v16 = 0; rdy16 = 1;

        // Reset with operations in flight
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            v16 = 1; rdy16 = 0; a16 = 16'(i + 1); b16 = 0; sub16 = 0; cin16 = 0;
        end
        @(negedge clk);
        v16 = 0;
        chk("midrst_pre_valid", ov16, 1);
        #2 rst_n = 0;
        #1 chk("midrst_drop", ov16, 0);
        @(negedge clk);
        rst_n = 1; rdy16 = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_old", ov16, 0);
        end
        dir_op(1, "post_rst", 16'h1234, 16'h1111, 0, 0, 16'h2345, 0, 0);

        // Random scoreboard on both configurations concurrently
        nin = 0; nout = 0; n8in = 0; n8out = 0;
        for (int cyc = 0; cyc < 20000 && !(nout == NR && n8out == NR); cyc++) begin
            @(negedge clk);
            if (ov16) begin
                if (q16.size() == 0) chk("r16_spurious", ov16, 0);
                else begin
                    e16 = q16[0];
                    chk("r16_sum", sum16, e16[15:0]);
                    chk("r16_cout", co16, e16[16]);
                    chk("r16_ovf", of16, e16[17]);
                end
            end
            if (ov8) begin
                if (q8.size() == 0) chk("r8_spurious", ov8, 0);
                else begin
                    e8 = q8[0];
                    chk("r8_sum", sum8, e8[7:0]);
                    chk("r8_cout", co8, e8[8]);
                    chk("r8_ovf", of8, e8[9]);
                end
            end
            rdy16 = ($urandom_range(3) != 0);
            v16   = (nin < NR) && ($urandom_range(3) != 0);
            a16 = 16'($urandom); b16 = 16'($urandom);
            cin16 = 1'($urandom); sub16 = 1'($urandom);
            rdy8  = ($urandom_range(3) != 0);
            v8    = (n8in < NR) && ($urandom_range(3) != 0);
            a8 = 8'($urandom); b8 = 8'($urandom);
            cin8 = 1'($urandom); sub8 = 1'($urandom);
            #1;
            if (ov16 && rdy16 && q16.size() != 0) begin
                void'(q16.pop_front());
                nout++;
            end
            if (v16 && ir16) begin
                q16.push_back(ref16(a16, b16, cin16, sub16));
                nin++;
            end
            if (ov8 && rdy8 && q8.size() != 0) begin
                void'(q8.pop_front());
                n8out++;
            end
            if (v8 && ir8) begin
                q8.push_back(ref8(a8, b8, cin8, sub8));
                n8in++;
            end
        end
        chk("r16_count", nout, NR);
        chk("r8_count", n8out, NR);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
